// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and an iterative shift-add multiply
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] Ain,
   input  logic [WIDTH-1:0] Bin,
   input  logic [2:0]       ALUop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [2:0]       Z,
   output logic             busy
);
   localparam int SW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
   state_t state, state_nxt;
   logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
   logic [WIDTH-1:0] mplier, res, sum, diff;
   logic [SW-1:0] cnt;
   logic accept, is_mul, last, ovf;
   assign in_ready = (state == IDLE) | (state == HOLD & out_ready);
   assign accept = in_valid & in_ready;
   assign is_mul = ALUop == 3'b111;
   assign last = (state == MUL) && (cnt == SW'(WIDTH - 1));
   assign out_valid = state == HOLD;
   assign busy = state == MUL;
   assign sum = Ain + Bin;
   assign diff = Ain - Bin;
   assign acc_nxt = acc + (mplier[0] ? mcand : '0);
   always_comb begin
      res = '0;
      ovf = 1'b0;
      case (ALUop)
         3'b000: begin
            res = sum;
            ovf = ~(Ain[WIDTH-1] ^ Bin[WIDTH-1]) & (Ain[WIDTH-1] ^ sum[WIDTH-1]);
         end
         3'b001: begin
            res = diff;
            ovf = (Ain[WIDTH-1] ^ Bin[WIDTH-1]) & (Ain[WIDTH-1] ^ diff[WIDTH-1]);
         end
         3'b010: res = Ain & Bin;
         3'b011: res = ~Bin;
         3'b100: res = Ain | Bin;
         3'b101: res = Ain ^ Bin;
         3'b110: res = Ain << Bin[SW-1:0];
         default: res = '0;
      endcase
   end
   // accept is only possible outside MUL, so it takes priority over completion
   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = is_mul ? MUL : HOLD;
      else if (last) state_nxt = HOLD;
      else if (state == HOLD && out_ready) state_nxt = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         out <= '0;
         Z <= '0;
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
         cnt <= '0;
      end else begin
         state <= state_nxt;
         if (accept && is_mul) begin
            mcand <= {{WIDTH{1'b0}}, Ain};
            mplier <= Bin;
            acc <= '0;
            cnt <= '0;
         end else if (accept) begin
            out <= res;
            Z <= {ovf, res[WIDTH-1], res == '0};
         end else if (state == MUL) begin
            acc <= acc_nxt;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + 1'b1;
            if (last) begin
               out <= acc_nxt[WIDTH-1:0];
               Z <= {|acc_nxt[2*WIDTH-1:WIDTH], acc_nxt[WIDTH-1], acc_nxt[WIDTH-1:0] == '0};
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq, random and directed traffic against an arithmetic model
module tb_alu_seq;
   localparam int W = 16;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   logic in_valid = 0, out_ready = 0, in_ready, out_valid, busy;
   logic [W-1:0] ain = 0, bin = 0, out;
   logic [2:0] op = 0, z;
   logic v8 = 0, rdy8 = 0, irdy8, ov8, busy8;
   logic [7:0] a8 = 0, b8 = 0, o8;
   logic [2:0] op8 = 0, z8;
   int checks = 0, failures = 0;
   logic [34:0] q[$];
   int mul_left = 0;
   bit held = 0;

   alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .Ain(ain), .Bin(bin), .ALUop(op), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .Z(z), .busy(busy));
   alu_seq #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(irdy8),
      .Ain(a8), .Bin(b8), .ALUop(op8), .out_valid(ov8), .out_ready(rdy8),
      .out(o8), .Z(z8), .busy(busy8));

   // result {Z, out} from signed/unsigned integer arithmetic on w-bit operands
   function automatic logic [34:0] ref_model(int w, logic [2:0] o, longint a, longint b);
      longint m = (longint'(1) << w) - 1;
      longint h = longint'(1) << (w - 1);
      longint sa = a >= h ? a - (m + 1) : a;
      longint sb = b >= h ? b - (m + 1) : b;
      longint r;
      bit v = 0;
      case (o)
         3'd0: begin r = sa + sb; v = r >= h || r < -h; end
         3'd1: begin r = sa - sb; v = r >= h || r < -h; end
         3'd2: r = a & b;
         3'd3: r = ~b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = a << (b % w);
         default: begin r = a * b; v = r > m; end
      endcase
      r = r & m;
      return {v, r >= h, r == 0, 32'(r)};
   endfunction

   task automatic chk(string name, logic [34:0] act, logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every presented result must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got out=%h Z=%b expected none", out, z);
         end else begin
            chk("result", 35'({z, out}), 35'({q[0][34:32], q[0][W-1:0]}));
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   // one clock of stimulus; handshake expectations come from a cycle-count model
   task automatic cycle(bit v, logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b, bit ordy);
      bit acc;
      in_valid = v; op = o; ain = a; bin = b; out_ready = ordy;
      @(negedge clk);
      chk("in_ready", 35'(in_ready), 35'((mul_left == 0) && (!held || ordy)));
      chk("busy", 35'(busy), 35'(mul_left > 0));
      chk("out_valid", 35'(out_valid), 35'(held));
      acc = v && mul_left == 0 && (!held || ordy);
      if (acc) q.push_back(ref_model(W, o, a, b));
      @(posedge clk);
      held = (held && !ordy) || mul_left == 1 || (acc && o != 3'd7);
      mul_left = (acc && o == 3'd7) ? W : (mul_left > 0 ? mul_left - 1 : 0);
      #1;
   endtask

   initial begin
      logic [34:0] e;
      #12;
      chk("reset_out", 35'({z, out, out_valid, busy}), 35'(0));
      @(negedge clk) rst_n = 1;
      @(posedge clk) #1;
      chk("reset_in_ready", 35'(in_ready), 35'(1));
      cycle(1, 3'd0, 16'h7FFF, 16'h0001, 1);
      cycle(1, 3'd1, 16'h0005, 16'h0005, 1);
      cycle(1, 3'd2, 16'hF0F0, 16'h0FF0, 1);
      cycle(1, 3'd7, 16'h0003, 16'h0005, 1);
      for (int i = 0; i < W + 1; i++) cycle(0, 3'd0, 16'h0, 16'h0, 1);
      cycle(1, 3'd7, 16'h0100, 16'h0100, 1);
      for (int i = 0; i < W + 1; i++) cycle(0, 3'd0, 16'h0, 16'h0, 1);
      cycle(1, 3'd5, 16'hAAAA, 16'hFFFF, 0);
      for (int i = 0; i < 5; i++) cycle(1, 3'd0, 16'h1234, 16'h1111, 0);
      cycle(0, 3'd0, 16'h0, 16'h0, 1);
      cycle(0, 3'd0, 16'h0, 16'h0, 1);
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
               16'($urandom), $urandom_range(0, 3) != 0);
      for (int i = 0; i < W + 4 && (q.size() != 0 || mul_left != 0); i++)
         cycle(0, 3'd0, 16'h0, 16'h0, 1);
      chk("drained", 35'(q.size()), 35'(0));
      // abort a multiply at step 7 with an asynchronous reset
      cycle(1, 3'd7, 16'h1234, 16'h5678, 1);
      for (int i = 0; i < 6; i++) cycle(0, 3'd0, 16'h0, 16'h0, 1);
      rst_n = 0;
      #1;
      chk("abort_outputs", 35'({z, out, out_valid, busy}), 35'(0));
      q.delete();
      mul_left = 0;
      held = 0;
      @(negedge clk) rst_n = 1;
      #1;
      chk("abort_in_ready", 35'(in_ready), 35'(1));
      @(posedge clk) #1;
      for (int i = 0; i < W + 4; i++) cycle(0, 3'd0, 16'h0, 16'h0, 1);
      // 8-bit instance: shift amount masking and multiply latency
      v8 = 1; op8 = 3'd6; a8 = 8'h81; b8 = 8'h09; rdy8 = 1;
      @(posedge clk) #1;
      e = ref_model(8, 3'd6, 64'h81, 64'h09);
      chk("w8_shl", 35'({ov8, z8, o8}), 35'({1'b1, e[34:32], e[7:0]}));
      op8 = 3'd7; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk) #1;
      v8 = 0;
      for (int i = 1; i < 8; i++) begin
         @(posedge clk) #1;
         chk("w8_mul_busy", 35'({busy8, ov8, irdy8}), 35'(3'b100));
      end
      @(posedge clk) #1;
      e = ref_model(8, 3'd7, 64'hFF, 64'hFF);
      chk("w8_mul", 35'({busy8, ov8, z8, o8}), 35'({2'b01, e[34:32], e[7:0]}));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
